vga_frame_scanout: RTL and testbench
====================================

// Module: vga_frame_scanout
// PURPOSE
//  Downstream consumer of the 640x480 6-bit videoMem written by the image/font placer.
//  Generates 640x480@60 VGA timing and fetches pixels linearly from videoMem.
//  Expands each 6-bit RRGGBB pixel to 24-bit RGB.
//  Provides a frame-start strobe so the CPU can schedule placer commands in vertical blank.
// PARAMETERS
//  H_VIS 640 visible pixels/line;  H_FP 16;  H_SYNC 96;  H_BP 48  (line total 800)
//  V_VIS 480 visible lines;        V_FP 10;  V_SYNC 2;   V_BP 33  (frame total 525)
//  RD_LAT 1  videoMem read latency in clk cycles (1 or 2)
// PORTS
//  clk         in   1   pixel clock (25 MHz)
//  rst_n       in   1   async active-low reset
//  en          in   1   display enable; level, sampled each clk
//  raddr       out  19  videoMem read address (0..307199)
//  rdata       in   6   videoMem read data {r[1:0],g[1:0],b[1:0]}, valid RD_LAT clks after raddr
//  VGA_R       out  8   red
//  VGA_G       out  8   green
//  VGA_B       out  8   blue
//  VGA_HS      out  1   hsync, active low
//  VGA_VS      out  1   vsync, active low
//  VGA_BLANK_N out  1   high during visible region
//  VGA_SYNC_N  out  1   tied 0
//  frame_start out  1   1-clk pulse at h=0,v=0 of the timing counters
//  vblank      out  1   high while v_cnt >= V_VIS
// BEHAVIOUR
//  Reset: h_cnt=0, v_cnt=0, raddr=0, RGB=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0,
//   frame_start=0, state=OFF.
//  Counters:
//   h_cnt 0..799, wraps to 0; at wrap, v_cnt increments 0..524, wraps to 0.
//   Counters run regardless of state.
//  Sync (stage 0, from counters):
//   hs0 = !(656 <= h_cnt <= 751); vs0 = !(490 <= v_cnt <= 491)
//   vis0 = (h_cnt < 640) && (v_cnt < 480)
//  Address:
//   raddr is a linear counter, no multiplier.
//   Increments by 1 on each clk where vis0=1.
//   Forced to 0 on the clk where h_cnt=799 && v_cnt=524.
//   Max value 307199; never exceeds it.
//   raddr presented combinationally from the counter in the same stage as vis0.
//  Pipeline:
//   hs0/vs0/vis0 are delayed RD_LAT+1 clks to align with registered RGB.
//   Output latency counter->pins = RD_LAT+1 clks.
//   Sync pulses, BLANK_N and RGB are all shifted by the same latency.
//  Colour expansion (registered): VGA_R = {4{rdata[5:4]}}; VGA_G = {4{rdata[3:2]}};
//   VGA_B = {4{rdata[1:0]}}; e.g. 6'h24 -> R=AA, G=55, B=00.
//  RGB forced to 0 when delayed vis=0 or state != ON.
//  FSM:
//   OFF:  RGB=0, syncs still driven. en=1 -> WAIT.
//   WAIT: RGB=0. en=0 -> OFF; frame_start -> ON. Never starts mid-frame.
//   ON:   RGB from rdata. en=0 -> DRAIN.
//   DRAIN: keep displaying until end of current frame (h=799, v=524) -> OFF;
//          en=1 during DRAIN -> ON.
//  frame_start: 1-clk pulse when h_cnt=0 && v_cnt=0, in every state (undelayed).
//  vblank: combinational from v_cnt (undelayed).
//  Async reset mid-frame: everything returns to reset values immediately;
//   the next frame starts from h=0,v=0.
// TESTING
//  1. Reset release, en=0, run 1 frame -> 420000 clks between frame_start pulses;
//     HS low 96 clks/line; VS low 1600 clks; RGB=0 throughout.
//  2. Memory model rdata = raddr[5:0], RD_LAT=1, en=1 -> first ON frame: pixel (0,0)
//     has RGB 0/0/0; pixel (37,0) (6'h25) -> AA/55/55 on the pins 2 clks after h_cnt=37.
//  3. Check raddr over a frame -> 0..307199 monotonic, +1 only while visible,
//     raddr=307199 at (639,479), then 0 at frame wrap.
//  4. Assert en mid-frame at v=100 -> RGB stays 0 until the next frame_start;
//     deassert at v=200 of a later frame -> video continues to end of that frame, then 0.
//  5. Assert rst_n=0 at h=300,v=250 for 3 clks -> HS=VS=1, BLANK_N=0, raddr=0;
//     after release, first frame_start occurs 0 clks later (h=v=0) and timing is correct.
//  6. RD_LAT=2 build -> same pixel/sync alignment as test 2 with latency 3.

Source files
------------

// File: rtl/vga_frame_scanout.sv
// vga_frame_scanout: VGA timing generator that scans a linear 6-bit framebuffer out as 24-bit RGB.
module vga_frame_scanout #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [18:0] raddr,
  input  logic [5:0]  rdata,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        frame_start,
  output logic        vblank
);
  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam logic [HW-1:0] H_END = HW'(HT - 1);
  localparam logic [HW-1:0] H_VE  = HW'(H_VIS);
  localparam logic [HW-1:0] H_SB  = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] H_SE  = HW'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_END = VW'(VT - 1);
  localparam logic [VW-1:0] V_VE  = VW'(V_VIS);
  localparam logic [VW-1:0] V_SB  = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] V_SE  = VW'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [18:0]   A_MAX = 19'(H_VIS * V_VIS - 1);

  typedef enum logic [1:0] {S_OFF, S_WAIT, S_ON, S_DRAIN} state_e;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [18:0]   addr_q, addr_d;
  logic [RD_LAT:0] hs_q, hs_d, vs_q, vs_d, vis_q, vis_d;
  logic [23:0]   rgb_q, rgb_d;
  state_e        state_q, state_d;
  logic          h_end, frame_end, hs0, vs0, vis0, show;

  assign frame_start = h_q == '0 && v_q == '0;
  assign vblank      = v_q >= V_VE;
  assign raddr       = addr_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_HS      = hs_q[RD_LAT];
  assign VGA_VS      = vs_q[RD_LAT];
  assign VGA_BLANK_N = vis_q[RD_LAT];
  assign {VGA_R, VGA_G, VGA_B} = rgb_q;

  always_comb begin
    h_end     = h_q == H_END;
    frame_end = h_end && v_q == V_END;
    h_d       = h_end ? '0 : h_q + 1'b1;
    v_d       = !h_end ? v_q : (v_q == V_END ? '0 : v_q + 1'b1);
    hs0       = !(h_q >= H_SB && h_q <= H_SE);
    vs0       = !(v_q >= V_SB && v_q <= V_SE);
    vis0      = h_q < H_VE && v_q < V_VE;
    // wrap after the last visible pixel so the address never passes the framebuffer end
    addr_d    = (frame_end || (vis0 && addr_q == A_MAX)) ? '0 : addr_q + 19'(vis0);
    hs_d      = {hs_q[RD_LAT-1:0], hs0};
    vs_d      = {vs_q[RD_LAT-1:0], vs0};
    vis_d     = {vis_q[RD_LAT-1:0], vis0};
    // vis delayed RD_LAT lines up with rdata; the RGB register adds the final stage
    show      = vis_q[RD_LAT-1] && (state_q == S_ON || state_q == S_DRAIN);
    rgb_d     = show ? {{4{rdata[5:4]}}, {4{rdata[3:2]}}, {4{rdata[1:0]}}} : '0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_OFF:   state_d = en ? S_WAIT : S_OFF;
      S_WAIT:  state_d = !en ? S_OFF : (frame_start ? S_ON : S_WAIT);
      S_ON:    state_d = en ? S_ON : S_DRAIN;
      S_DRAIN: state_d = en ? S_ON : (frame_end ? S_OFF : S_DRAIN);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q     <= '0;
      v_q     <= '0;
      addr_q  <= '0;
      hs_q    <= '1;
      vs_q    <= '1;
      vis_q   <= '0;
      rgb_q   <= '0;
      state_q <= S_OFF;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      addr_q  <= addr_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      vis_q   <= vis_d;
      rgb_q   <= rgb_d;
      state_q <= state_d;
    end
  end
endmodule

// File: tb/tb_vga_frame_scanout.sv
// tb_vga_frame_scanout: scoreboard bench for two scanout builds (RD_LAT 1 and 2) on a reduced raster.
module tb_vga_frame_scanout;
  localparam int HV = 40, HF = 4, HSY = 6, HB = 4;
  localparam int VV = 6, VF = 2, VSY = 2, VB = 3;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VT = VV + VF + VSY + VB;
  localparam int FT = HT * VT;
  localparam int NPIX = HV * VV;

  typedef struct packed {logic hs; logic vs; logic bl; logic [23:0] rgb;} pin_t;
  typedef struct packed {logic [18:0] ra; logic fs; logic vb;} now_t;
  localparam pin_t RST = '{1'b1, 1'b1, 1'b0, 24'd0};

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, en_v = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] mem [0:NPIX-1];
  logic [18:0] ra1, ra2;
  logic [5:0] rd1, rd2a, rd2;
  logic [7:0] r1, g1, b1, r2, g2, b2;
  logic hs1, vs1, bl1, sn1, fs1, vb1, hs2, vs2, bl2, sn2, fs2, vb2;

  always @(posedge clk) begin
    rd1  <= mem[int'(ra1)];
    rd2a <= mem[int'(ra2)];
    rd2  <= rd2a;
  end

  vga_frame_scanout #(.H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB), .V_VIS(VV), .V_FP(VF),
    .V_SYNC(VSY), .V_BP(VB), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .raddr(ra1), .rdata(rd1), .VGA_R(r1), .VGA_G(g1),
    .VGA_B(b1), .VGA_HS(hs1), .VGA_VS(vs1), .VGA_BLANK_N(bl1), .VGA_SYNC_N(sn1),
    .frame_start(fs1), .vblank(vb1));

  vga_frame_scanout #(.H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB), .V_VIS(VV), .V_FP(VF),
    .V_SYNC(VSY), .V_BP(VB), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .raddr(ra2), .rdata(rd2), .VGA_R(r2), .VGA_G(g2),
    .VGA_B(b2), .VGA_HS(hs2), .VGA_VS(vs2), .VGA_BLANK_N(bl2), .VGA_SYNC_N(sn2),
    .frame_start(fs2), .vblank(vb2));

  int n_vec = 0, n_err = 0;
  int pos = 0;
  bit live = 0, prev_en = 0;
  now_t q_now[$];
  pin_t q_pin1[$], q_pin2[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Raster position -> expected undelayed outputs; raddr counts visible pixels already passed.
  function automatic now_t exp_now(input int p);
    int h, v;
    now_t e;
    h = p % HT;
    v = p / HT;
    e.ra = 19'((v < VV ? v * HV + (h < HV ? h : HV) : 0) % NPIX);
    e.fs = p == 0;
    e.vb = v >= VV;
    return e;
  endfunction

  function automatic pin_t exp_pin(input int p, input bit lv);
    int h, v;
    logic [5:0] d;
    pin_t e;
    h = p % HT;
    v = p / HT;
    e.bl = h < HV && v < VV;
    e.hs = !(h >= HV + HF && h < HV + HF + HSY);
    e.vs = !(v >= VV + VF && v < VV + VF + VSY);
    d = e.bl ? mem[v * HV + h] : 6'd0;
    e.rgb = (e.bl && lv) ? {8'(d[5:4] * 85), 8'(d[3:2] * 85), 8'(d[1:0] * 85)} : 24'd0;
    return e;
  endfunction

  // One clock of stimulus; a frame is displayed iff en was already high entering its first pixel.
  task automatic step(input bit r);
    pin_t p;
    @(posedge clk);
    #1;
    rst_n = r;
    en = en_v;
    if (!r) begin
      pos = 0;
      live = 0;
      prev_en = 0;
      q_now.delete();
      q_pin1 = '{RST, RST};
      q_pin2 = '{RST, RST, RST};
    end else begin
      if (pos == 0) live = en && prev_en;
      q_now.push_back(exp_now(pos));
      p = exp_pin(pos, live);
      q_pin1.push_back(p);
      q_pin2.push_back(p);
      prev_en = en;
      pos = (pos + 1) % FT;
    end
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < FT && pos != p; i++) step(1'b1);
  endtask

  task automatic frame();
    run_to(1);
    run_to(0);
  endtask

  initial begin
    now_t n;
    pin_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_hs1", hs1, 1'b1);
        chk("rst_vs1", vs1, 1'b1);
        chk("rst_blank1", bl1, 1'b0);
        chk("rst_raddr1", ra1, 0);
        chk("rst_rgb1", {r1, g1, b1}, 0);
        chk("rst_hs2", hs2, 1'b1);
        chk("rst_blank2", bl2, 1'b0);
        chk("rst_raddr2", ra2, 0);
      end else if (q_now.size() == 0 || q_pin1.size() == 0 || q_pin2.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard_underflow: got empty queue expected entry at t=%0t", $time);
      end else begin
        n = q_now.pop_front();
        chk("raddr1", ra1, n.ra);
        chk("raddr2", ra2, n.ra);
        chk("frame_start1", fs1, n.fs);
        chk("frame_start2", fs2, n.fs);
        chk("vblank1", vb1, n.vb);
        chk("vblank2", vb2, n.vb);
        chk("sync_n", {sn1, sn2}, 0);
        e = q_pin1.pop_front();
        chk("hs1", hs1, e.hs);
        chk("vs1", vs1, e.vs);
        chk("blank1", bl1, e.bl);
        chk("rgb1", {r1, g1, b1}, e.rgb);
        e = q_pin2.pop_front();
        chk("hs2", hs2, e.hs);
        chk("vs2", vs2, e.vs);
        chk("blank2", bl2, e.bl);
        chk("rgb2", {r2, g2, b2}, e.rgb);
      end
    end
  end

  initial begin
    for (int i = 0; i < NPIX; i++) mem[i] = 6'($urandom);
    mem[0] = 6'h00;
    mem[37] = 6'h25;
    repeat (3) step(1'b0);
    frame();
    frame();
    run_to(2 * HT + 5);
    en_v = 1'b1;
    run_to(0);
    frame();
    frame();
    run_to(4 * HT + 7);
    en_v = 1'b0;
    run_to(0);
    frame();
    repeat (12) begin
      run_to($urandom_range(FT - HT, HT));
      en_v = 1'($urandom);
      run_to(0);
    end
    en_v = 1'b1;
    frame();
    run_to(3 * HT + 30);
    repeat (3) step(1'b0);
    frame();
    frame();
    frame();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
